// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the 512Kx16 asynchronous SRAM initiator.
package sram_pkg;

    localparam int SRAM_ADDR_W  = 19;
    localparam int SRAM_DATA_W  = 16;
    localparam int SRAM_WR_WAIT = 2;
    localparam int SRAM_RD_WAIT = 2;
    localparam int SRAM_CNT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_WAIT
    } sram_state_t;

    // The wait counter runs down to zero, so an N-cycle phase loads N-1.
    function automatic logic [SRAM_CNT_W-1:0] wait_load(input int cycles);
        return SRAM_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Single-word read/write initiator that sequences address, write data and the
// write strobe for the SRAM pin driver with setup, pulse and hold timing.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W  = SRAM_ADDR_W,
    parameter int DATA_W  = SRAM_DATA_W,
    parameter int WR_WAIT = SRAM_WR_WAIT,
    parameter int RD_WAIT = SRAM_RD_WAIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dataw,
    input  logic [DATA_W-1:0] datar,
    output logic              we
);

    localparam logic [SRAM_CNT_W-1:0] WR_LOAD = wait_load(WR_WAIT);
    localparam logic [SRAM_CNT_W-1:0] RD_LOAD = wait_load(RD_WAIT);
    localparam logic [SRAM_CNT_W-1:0] CNT_ONE = SRAM_CNT_W'(1);

    sram_state_t           state;
    logic [SRAM_CNT_W-1:0] cnt;

    assign req_ready = (state == IDLE);

    // Reset drops we asynchronously so the driver releases the data bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            address   <= '0;
            dataw     <= '0;
            we        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        address <= req_addr;
                        if (req_we) begin
                            dataw <= req_wdata;
                            state <= W_SETUP;
                        end else begin
                            cnt   <= RD_LOAD;
                            state <= R_WAIT;
                        end
                    end
                end
                W_SETUP: begin
                    we    <= 1'b1;
                    cnt   <= WR_LOAD;
                    state <= W_PULSE;
                end
                W_PULSE: begin
                    if (cnt == '0) begin
                        we    <= 1'b0;
                        state <= W_HOLD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                W_HOLD: begin
                    state <= IDLE;
                end
                R_WAIT: begin
                    if (cnt == '0) begin
                        rsp_rdata <= datar;
                        rsp_valid <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    we    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
